// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory-port responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lc3_mem_pkg;

   // Responder sequencing states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      ACCESS  = 3'd2,
      DONE    = 3'd3,
      RELEASE = 3'd4
   } mem_state_t;

   // Default address decoded as memory-mapped I/O rather than SRAM
   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

   // Board SRAM address bus width
   localparam int SRAM_AW = 20;

endpackage

// File: rtl/reg16.sv
// 16-bit load-enabled hold register with synchronous active-high reset.
// Latency: q updates on the clock edge where load is high.
// Backpressure: none; q holds its value whenever load is low.
//
// Ports:
//   Clk, Reset  clock and synchronous active-high reset (clears q)
//   load        capture d on the next edge
//   d / q       16-bit data in / held data out
module reg16 (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        load,
   input  logic [15:0] d,
   output logic [15:0] q
);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-port responder: serves CPU requests from async SRAM or the I/O address.
// Latency: R rises one edge after the FSM enters DONE (E0+1 for I/O, E0+WAIT_CYCLES+2 for SRAM).
// Backpressure: one request at a time; a held MIO_EN parks in RELEASE until it drops.
//
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   MIO_EN, R_W, MAR, MDR CPU request (held until R), direction, address, write data
//   MDR_In, R             read data held for the CPU, one-cycle ready pulse
//   Switches, HEX_Data    I/O read source, I/O write target
//   SRAM_*                board SRAM address, data (split in/out + tristate enable), strobes
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               MIO_EN,
   input  logic               R_W,
   input  logic [15:0]        MAR,
   input  logic [15:0]        MDR,
   output logic [15:0]        MDR_In,
   output logic               R,
   input  logic [15:0]        Switches,
   output logic [15:0]        HEX_Data,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [15:0]        SRAM_DQ_O,
   input  logic [15:0]        SRAM_DQ_I,
   output logic               SRAM_DQ_OE,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Request captured at acceptance so the CPU side may change afterwards
   logic [15:0] addr_q;
   logic [15:0] data_q;
   logic        wr_q;
   logic        io_q;

   // Next values for the registered outputs, decoded from the current state
   logic r_d, ce_n_d, oe_n_d, we_n_d, bank_n_d, dq_oe_d;

   logic        mdr_load;
   logic        hex_load;
   logic [15:0] mdr_next;

   // ---------------- state / request registers ----------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         io_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && MIO_EN) begin
            addr_q <= MAR;
            data_q <= MDR;
            wr_q   <= R_W;
            io_q   <= (MAR == IO_ADDR);
         end
      end
   end

   // ---------------- next state and output decode ----------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      r_d      = 1'b0;
      ce_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b1;
      bank_n_d = 1'b1;
      dq_oe_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (MIO_EN) begin
               state_d = (MAR == IO_ADDR) ? DONE : SETUP;
            end
         end
         SETUP: begin
            ce_n_d   = 1'b0;
            bank_n_d = 1'b0;
            dq_oe_d  = wr_q;
            cnt_d    = CNT_W'(WAIT_CYCLES);
            state_d  = ACCESS;
         end
         ACCESS: begin
            ce_n_d   = 1'b0;
            bank_n_d = 1'b0;
            // Exactly one of OE_N/WE_N is low; the bus is only driven on writes
            oe_n_d   = wr_q;
            we_n_d   = ~wr_q;
            dq_oe_d  = wr_q;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            r_d     = 1'b1;
            // Keep driving write data one cycle past WE_N rising for hold time
            dq_oe_d = wr_q & ~io_q;
            state_d = RELEASE;
         end
         RELEASE: begin
            // A request still held after R must not trigger a second access
            if (!MIO_EN) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- registered outputs ----------------
   // Every pin lags the state by one edge, so the edge that leaves the last
   // strobe cycle (state DONE) is also the edge that samples read data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         R          <= 1'b0;
         SRAM_CE_N  <= 1'b1;
         SRAM_OE_N  <= 1'b1;
         SRAM_WE_N  <= 1'b1;
         SRAM_UB_N  <= 1'b1;
         SRAM_LB_N  <= 1'b1;
         SRAM_DQ_OE <= 1'b0;
         SRAM_ADDR  <= '0;
         SRAM_DQ_O  <= '0;
      end else begin
         R          <= r_d;
         SRAM_CE_N  <= ce_n_d;
         SRAM_OE_N  <= oe_n_d;
         SRAM_WE_N  <= we_n_d;
         SRAM_UB_N  <= bank_n_d;
         SRAM_LB_N  <= bank_n_d;
         SRAM_DQ_OE <= dq_oe_d;
         if (state_q == SETUP) begin
            SRAM_ADDR <= {{(SRAM_AW - 16){1'b0}}, addr_q};
            if (wr_q) begin
               SRAM_DQ_O <= data_q;
            end
         end
      end
   end

   // ---------------- CPU-visible hold registers ----------------
   assign mdr_load = (state_q == DONE) && !wr_q;
   assign mdr_next = io_q ? Switches : SRAM_DQ_I;
   assign hex_load = (state_q == DONE) && wr_q && io_q;

   reg16 u_mdr_in (
      .Clk   (Clk),
      .Reset (Reset),
      .load  (mdr_load),
      .d     (mdr_next),
      .q     (MDR_In)
   );

   reg16 u_hex (
      .Clk   (Clk),
      .Reset (Reset),
      .load  (hex_load),
      .d     (data_q),
      .q     (HEX_Data)
   );

endmodule
